// File: rtl/i2c_slave_menu_ctrl.sv
// Menu navigation controller for the I2C slave front panel.
// Turns debounced button levels into menu ROM indices for the two LCD lines,
// runs the two-level menu and the Clear RAM confirmation, and hands off to
// datapath actions through mode/clearReq. lcdRefresh pulses on page changes.
module i2c_slave_menu_ctrl #(
  parameter logic [3:0] BLANK_IDX = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnSelect,
  input  logic       btnBack,
  input  logic       clearAck,
  output logic [3:0] titleSelect,
  output logic [3:0] optionSelect,
  output logic [2:0] mode,
  output logic       clearReq,
  output logic       lcdRefresh
);

  typedef enum logic [2:0] {
    MAIN     = 3'd0,
    SLAVE    = 3'd1,
    ACTIVE   = 3'd2,
    CONFIRM  = 3'd3,
    CLEARING = 3'd4
  } state_t;

  state_t     state;
  logic [1:0] cursor;
  logic [3:0] item;        // menu index of the running action while ACTIVE
  logic       firstCycle;  // forces one refresh right after reset
  logic       upQ, downQ, selQ, backQ;

  logic       upP, downP, selP, backP;
  logic       moveUp, moveDown;
  logic [3:0] slaveItem;
  logic [3:0] nextTitle, nextOption;
  logic [2:0] nextMode;
  logic       nextClear;

  // Rising-edge press detection; Up and Down together cancel each other
  always_comb begin
    upP      = btnUp & ~upQ;
    downP    = btnDown & ~downQ;
    selP     = btnSelect & ~selQ;
    backP    = btnBack & ~backQ;
    moveUp   = upP & ~downP;
    moveDown = downP & ~upP;
  end

  // Map the SLAVE cursor position onto its menu ROM index
  always_comb begin
    case (cursor)
      2'd0:    slaveItem = 4'd2;
      2'd1:    slaveItem = 4'd3;
      2'd2:    slaveItem = 4'd4;
      2'd3:    slaveItem = 4'd7;
      default: slaveItem = 4'd2;
    endcase
  end

  // Decode the page shown for the current state; outputs register this next edge
  always_comb begin
    nextTitle  = 4'd0;
    nextOption = 4'd1;
    nextMode   = 3'd0;
    nextClear  = 1'b0;
    case (state)
      MAIN: begin
        nextTitle  = 4'd0;
        nextOption = (cursor == 2'd0) ? 4'd1 : 4'd5;
      end
      SLAVE: begin
        nextTitle  = 4'd5;
        nextOption = slaveItem;
      end
      ACTIVE: begin
        nextTitle  = item;
        nextOption = BLANK_IDX;
        case (item)
          4'd1:    nextMode = 3'd1;
          4'd2:    nextMode = 3'd2;
          4'd3:    nextMode = 3'd3;
          4'd7:    nextMode = 3'd4;
          default: nextMode = 3'd0;
        endcase
      end
      CONFIRM: begin
        nextTitle  = 4'd6;
        nextOption = 4'd4;
      end
      CLEARING: begin
        nextTitle  = 4'd6;
        nextOption = 4'd4;
        nextClear  = 1'b1;
      end
      default: begin
        nextTitle  = 4'd0;
        nextOption = 4'd1;
      end
    endcase
  end

  // Menu FSM, button edge registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= MAIN;
      cursor       <= 2'd0;
      item         <= 4'd0;
      firstCycle   <= 1'b1;
      upQ          <= 1'b0;
      downQ        <= 1'b0;
      selQ         <= 1'b0;
      backQ        <= 1'b0;
      titleSelect  <= 4'd0;
      optionSelect <= 4'd1;
      mode         <= 3'd0;
      clearReq     <= 1'b0;
      lcdRefresh   <= 1'b0;
    end else begin
      upQ          <= btnUp;
      downQ        <= btnDown;
      selQ         <= btnSelect;
      backQ        <= btnBack;
      firstCycle   <= 1'b0;
      titleSelect  <= nextTitle;
      optionSelect <= nextOption;
      mode         <= nextMode;
      clearReq     <= nextClear;
      lcdRefresh   <= firstCycle | (nextTitle != titleSelect) | (nextOption != optionSelect);

      // Back masks every other press in the same cycle, then Select, then Up/Down
      case (state)
        MAIN: begin
          if (backP) begin
            state <= MAIN;
          end else if (selP) begin
            if (cursor == 2'd0) begin
              state <= ACTIVE;
              item  <= 4'd1;
            end else begin
              state  <= SLAVE;
              cursor <= 2'd0;
            end
          end else if (moveDown) begin
            cursor <= (cursor == 2'd1) ? 2'd0 : cursor + 2'd1;
          end else if (moveUp) begin
            cursor <= (cursor == 2'd0) ? 2'd1 : cursor - 2'd1;
          end
        end
        SLAVE: begin
          if (backP) begin
            state  <= MAIN;
            cursor <= 2'd1;
          end else if (selP) begin
            if (cursor == 2'd2) begin
              state <= CONFIRM;
            end else begin
              state <= ACTIVE;
              item  <= slaveItem;
            end
          end else if (moveDown) begin
            cursor <= (cursor == 2'd3) ? 2'd0 : cursor + 2'd1;
          end else if (moveUp) begin
            cursor <= (cursor == 2'd0) ? 2'd3 : cursor - 2'd1;
          end
        end
        ACTIVE: begin
          // cursor was left untouched, so it still points at the launched item
          if (backP) begin
            state <= (item == 4'd1) ? MAIN : SLAVE;
          end
        end
        CONFIRM: begin
          if (backP) begin
            state  <= SLAVE;
            cursor <= 2'd2;
          end else if (selP) begin
            state <= CLEARING;
          end
        end
        CLEARING: begin
          if (clearAck) begin
            state  <= SLAVE;
            cursor <= 2'd2;
          end
        end
        default: begin
          state  <= MAIN;
          cursor <= 2'd0;
        end
      endcase
    end
  end

endmodule
